mem_tx_reader: RTL and testbench

MEM_TX_READER -- requirements
Module: mem_tx_reader

---
 rtl/mkio_pkg.sv | 29 ++
 rtl/mem_tx_reader.sv | 159 +++++++++++++++
 tb/tb_mem_tx_reader.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mkio_pkg.sv
// mkio_pkg
// Shared definitions for the MKIO transmit-side blocks.
//   mkio_state_e      : state encoding of the buffer-to-encoder reader FSM
//   mkio_decode_count : turns a word-count field into a real word count,
//                       where a field of zero means a full buffer
//                       (2**aw words)
package mkio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_LOAD    = 2'd2,
    ST_PRESENT = 2'd3
  } mkio_state_e;

  // Widths are passed as plain integers so that one function serves every
  // address width; callers narrow the result to their counter width.
  function automatic int unsigned mkio_decode_count(input int unsigned cnt,
                                                    input int unsigned aw);
    int unsigned result;
    if (cnt == 32'd0) begin
      result = 32'd1 << aw;
    end else begin
      result = cnt;
    end
    return result;
  endfunction

endpackage : mkio_pkg

// File: rtl/mem_tx_reader.sv
// mem_tx_reader
// Streams a block of words out of a registered-read buffer RAM towards the
// serial encoder, one word at a time with a valid/ready handshake.
//
// Ports
//   clk         : single clock, rising edge
//   rst_n       : synchronous active-low reset
//   start       : one-cycle request to begin a block transfer (IDLE only)
//   start_addr  : first buffer address, sampled with start
//   word_cnt    : word count, sampled with start; 0 means 2**ADDR_WIDTH
//   abort       : terminate the transfer in progress
//   rd_addr     : buffer RAM read address (registered)
//   rd_q        : RAM registered read data, valid one clock after rd_addr
//   tx_data     : word offered to the encoder
//   tx_valid    : qualifies tx_data
//   tx_ready    : encoder acceptance; a word moves when valid and ready
//   busy        : high from the cycle after an accepted start until IDLE
//   done        : one-cycle pulse after the last accept or after an abort
module mem_tx_reader
  import mkio_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] word_cnt,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_q,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  // One extra bit so a full buffer (2**ADDR_WIDTH words) fits the counter.
  localparam int CNT_WIDTH = ADDR_WIDTH + 1;

  mkio_state_e           state_q,    state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q,  rd_addr_d;
  logic [CNT_WIDTH-1:0]  cnt_q,      cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q,  tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;

  logic [CNT_WIDTH-1:0]  start_cnt;

  // Decoded word count for a start issued this cycle.
  always_comb begin
    start_cnt = CNT_WIDTH'(mkio_decode_count(32'(word_cnt), 32'(ADDR_WIDTH)));
  end

  // Next-state and datapath update for the reader FSM.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort alongside start suppresses the start entirely.
        if (start && !abort) begin
          rd_addr_d = start_addr;
          cnt_d     = start_cnt;
          state_d   = ST_FETCH;
        end else begin
          state_d   = ST_IDLE;
        end
      end

      ST_FETCH: begin
        // rd_addr is already on the RAM port; this cycle lets it capture.
        if (abort) begin
          cnt_d   = {CNT_WIDTH{1'b0}};
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (abort) begin
          cnt_d   = {CNT_WIDTH{1'b0}};
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tx_data_d = rd_q;
          state_d   = ST_PRESENT;
        end
      end

      ST_PRESENT: begin
        // abort wins over a simultaneous accept: the word is not counted.
        if (abort) begin
          cnt_d   = {CNT_WIDTH{1'b0}};
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tx_ready) begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // Natural wrap of the address register gives modulo addressing.
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
            state_d   = ST_FETCH;
          end
        end else begin
          state_d = ST_PRESENT;
        end
      end

      default: begin
        cnt_d   = {CNT_WIDTH{1'b0}};
        state_d = ST_IDLE;
      end
    endcase

    // Flags derived from the next state so they line up with it exactly.
    tx_valid_d = (state_d == ST_PRESENT);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_addr_q  <= {ADDR_WIDTH{1'b0}};
      cnt_q      <= {CNT_WIDTH{1'b0}};
      tx_data_q  <= {DATA_WIDTH{1'b0}};
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rd_addr  = rd_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule : mem_tx_reader

// File: tb/tb_mem_tx_reader.sv
// tb_mem_tx_reader
// Bench for mem_tx_reader paired with a registered-read buffer RAM model.
// Expected words are queued when a start is driven; a negedge monitor pops
// and compares them on every accept, checks done timing, valid latency and
// stability while stalled.
module tb_mem_tx_reader;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] word_cnt;
  logic          abort;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_q;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem [0:DEPTH-1];

  int cyc = 0;
  int ref_cyc = 0;
  bit lat_armed = 1'b0;
  bit prev_hold = 1'b0;
  bit prev_valid = 1'b0;
  logic [DW-1:0] prev_data = '0;
  bit exp_done_now = 1'b0;
  bit exp_done_next = 1'b0;
  int acc_cnt = 0;
  int done_cnt = 0;

  mem_tx_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .word_cnt   (word_cnt),
    .abort      (abort),
    .rd_addr    (rd_addr),
    .rd_q       (rd_q),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer RAM: preloaded pattern, registered read on the shared clock.
  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = 16'hA000 + 16'(k);
  end
  always @(posedge clk) rd_q <= mem[rd_addr];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    exp_done_now  = exp_done_next;
    exp_done_next = 1'b0;
    checks++;
    if (done !== exp_done_now) begin
      errors++;
      $display("FAIL done_pulse cyc=%0d got=%b exp=%b", cyc, done, exp_done_now);
    end
    if (done === 1'b1) done_cnt++;
    if (!rst_n) begin
      exp_q.delete();
      lat_armed  = 1'b0;
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_hold) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          errors++;
          $display("FAIL stall_stable cyc=%0d got valid=%b data=%h exp valid=1 data=%h",
                   cyc, tx_valid, tx_data, prev_data);
        end
      end
      if (tx_valid === 1'b1 && !prev_valid && lat_armed) begin
        checks++;
        if (cyc - ref_cyc != 3) begin
          errors++;
          $display("FAIL valid_latency cyc=%0d got=%0d exp=3", cyc, cyc - ref_cyc);
        end
      end
      if (abort && busy) begin
        exp_q.delete();
        exp_done_next = 1'b1;
        lat_armed = 1'b0;
      end else if (tx_valid === 1'b1 && tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word cyc=%0d got=%h exp=none", cyc, tx_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL word_data cyc=%0d got=%h exp=%h", cyc, tx_data, e);
          end
          if (exp_q.size() == 0) exp_done_next = 1'b1;
        end
        acc_cnt++;
        ref_cyc = cyc;
        lat_armed = 1'b1;
      end else if (start && !busy && !abort) begin
        ref_cyc = cyc;
        lat_armed = 1'b1;
      end
      prev_hold  = (tx_valid === 1'b1) && !tx_ready && !abort;
      prev_data  = tx_data;
      prev_valid = (tx_valid === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a start for one cycle and queue the words it must produce.
  task automatic start_xfer(input int a, input int n);
    int words;
    words = (n == 0) ? DEPTH : n;
    start_addr = AW'(a);
    word_cnt   = AW'(n);
    start      = 1'b1;
    for (int i = 0; i < words; i++) exp_q.push_back(16'hA000 + 16'((a + i) % DEPTH));
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s_timeout got busy=%b pending=%0d exp idle", tag, busy, exp_q.size());
    end
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (rd_addr !== 5'd0 || tx_data !== 16'd0 || tx_valid !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s got addr=%h data=%h valid=%b busy=%b done=%b exp all zero",
               tag, rd_addr, tx_data, tx_valid, busy, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    start_addr = '0; word_cnt = '0;
    step(); step();
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int a0, d0;
    a0 = acc_cnt; d0 = done_cnt;
    tx_ready = 1'b1;
    start_xfer(4, 3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got=%b exp=1", busy);
    end
    wait_idle("basic");
    checks++;
    if (acc_cnt - a0 != 3 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL basic_counts got words=%0d dones=%0d exp 3 1", acc_cnt - a0, done_cnt - d0);
    end
  endtask

  task automatic test_wrap();
    int a0;
    a0 = acc_cnt;
    start_xfer(30, 4);
    wait_idle("wrap");
    checks++;
    if (acc_cnt - a0 != 4) begin
      errors++;
      $display("FAIL wrap_count got=%0d exp=4", acc_cnt - a0);
    end
  endtask

  task automatic test_full();
    int a0;
    a0 = acc_cnt;
    start_xfer(0, 0);
    wait_idle("full");
    checks++;
    if (acc_cnt - a0 != 32 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_count got words=%0d busy=%b exp 32 0", acc_cnt - a0, busy);
    end
  endtask

  task automatic test_stall();
    int n = 0;
    tx_ready = 1'b0;
    start_xfer(10, 3);
    while (tx_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    repeat (5) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 16'hA00A) begin
        errors++;
        $display("FAIL stall_hold got valid=%b data=%h exp 1 a00a", tx_valid, tx_data);
      end
      step();
    end
    tx_ready = 1'b1;
    wait_idle("stall");
  endtask

  task automatic test_abort();
    int a0, n;
    a0 = acc_cnt;
    tx_ready = 1'b1;
    start_xfer(8, 5);
    n = 0;
    while (acc_cnt < a0 + 1 && n < 20) begin step(); n++; end
    n = 0;
    while (tx_valid !== 1'b1 && n < 20) begin step(); n++; end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || acc_cnt - a0 != 1) begin
      errors++;
      $display("FAIL abort_effect got valid=%b done=%b busy=%b words=%0d exp 0 1 0 1",
               tx_valid, done, busy, acc_cnt - a0);
    end
    step();
    // start together with abort in IDLE must start nothing
    start = 1'b1; abort = 1'b1; start_addr = 5'd2; word_cnt = 5'd2;
    step();
    start = 1'b0; abort = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b done=%b exp 0 0", busy, done);
    end
    start_xfer(0, 2);
    wait_idle("after_abort");
  endtask

  task automatic test_busy_reset();
    int a0, n;
    a0 = acc_cnt;
    tx_ready = 1'b1;
    start_xfer(12, 6);
    n = 0;
    while (acc_cnt < a0 + 2 && n < 30) begin step(); n++; end
    // start while busy: no words queued, must not disturb the transfer
    start = 1'b1; start_addr = 5'd20; word_cnt = 5'd1;
    step();
    start = 1'b0;
    n = 0;
    while (acc_cnt < a0 + 3 && n < 30) begin step(); n++; end
    checks++;
    if (busy !== 1'b1 || acc_cnt - a0 != 3) begin
      errors++;
      $display("FAIL busy_ignore got busy=%b words=%0d exp 1 3", busy, acc_cnt - a0);
    end
    rst_n = 1'b0;
    step();
    check_reset_outputs("midreset_state");
    step();
    rst_n = 1'b1;
    start_xfer(3, 1);
    wait_idle("post_reset");
    checks++;
    if (exp_q.size() != 0 || acc_cnt - a0 != 4) begin
      errors++;
      $display("FAIL post_reset_words got pending=%0d words=%0d exp 0 4",
               exp_q.size(), acc_cnt - a0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_full();
    test_stall();
    test_abort();
    test_busy_reset();
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_tx_reader
